lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side checker for the 4-bit load/count-enable LFSR counter.
- Samples the generator's state word on each valid strobe and self-synchronizes a local predictor to it.
- Once locked, flags every sample that deviates from the expected sequence, including the count_to→data wrap.
- Sits beside the generator in the lab bench as its autonomous monitor.

Parameters:
- width, 4, state/data word width.
- TAPS, 4'b1100, feedback tap mask; feedback bit = XOR-reduce(cur & TAPS).
- LOCK_CNT, 3, consecutive matches required in VERIFY to declare lock.
- LOSS_CNT, 2, consecutive mismatches in LOCKED that drop lock.
- CNT_W, 8, error counter width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  width  generator reload value; also the wrap target.
- count_to  input  width  generator terminal value.
- obs  input  width  observed generator state word.
- obs_valid  input  1  obs holds the next successive state this cycle.
- obs_load  input  1  with obs_valid: sample is a fresh load; reseed, no compare.
- locked  output  1  predictor is synchronized.
- err  output  1  one-cycle pulse per mismatching sample while LOCKED.
- err_cnt  output  CNT_W  saturating mismatch count.
- state_o  output  2  FSM state: HUNT=0, VERIFY=1, LOCKED=2.

Behaviour:
- Next function: nxt(x) = (x == count_to) ? data : {x[width-2:0], ^(x & TAPS)}.
- Reset: state HUNT, pred=0, match_cnt=0, miss_cnt=0, locked=0, err=0, err_cnt=0.
- All outputs are registered. Status (err, locked, state_o) reflects a sample on the cycle after obs_valid.
- No obs_valid: all state holds; err=0.
- HUNT, on obs_valid:
  - obs==0 and obs!=count_to: all-zero lockup word, ignored; stay HUNT.
  - Otherwise: pred <= nxt(obs), match_cnt <= 0, go VERIFY.
- VERIFY, on obs_valid:
  - obs==pred: pred <= nxt(pred), match_cnt++. On reaching LOCK_CNT, go LOCKED and set locked=1.
  - Mismatch: pred <= nxt(obs), match_cnt <= 0, stay VERIFY. No err pulse.
- LOCKED, on obs_valid:
  - obs==pred: pred <= nxt(pred), miss_cnt <= 0.
  - Mismatch: err=1 for one cycle, err_cnt++ (saturates at all-ones, never wraps), pred <= nxt(pred) (flywheel, not obs), miss_cnt++.
  - miss_cnt reaching LOSS_CNT: go HUNT, locked=0, miss_cnt <= 0.
- obs_load & obs_valid, in any state:
  - pred <= nxt(obs); no compare, no err.
  - HUNT→VERIFY (zero rule does not apply); VERIFY clears match_cnt; LOCKED stays LOCKED with miss_cnt cleared.
- data or count_to change mid-run: takes effect on the next nxt() evaluation; no other action.
- reset asserted mid-operation: full return to reset values on the next edge; err_cnt cleared.

Optional Feature:
- LFSR_CHK_STICKY_EN
  - Defined: adds output err_sticky (1 bit). Set on the first LOCKED mismatch; held until reset. Reset value 0.
  - Undefined: port absent; only the err pulse and err_cnt exist.

Test Plan:
- Setup for all tests: data=0111, count_to=1100, default parameters. Expected cycle: 0111→1111→1110→1100→0111.
- Reset, then valid samples 0111,1111,1110,1100 → VERIFY after 1st; locked=1 the cycle after the 4th; err_cnt=0.
- Locked, inject 1010 in place of 0111, then continue the correct sequence → one err pulse, err_cnt=1, locked stays 1. Following 1111 matches via flywheel.
- Locked, two consecutive wrong samples (0000,0000) → err_cnt=2, state_o=HUNT, locked=0. Resync on correct stream relocks after 4 samples.
- HUNT with obs=0000 valid → remains HUNT. Then obs_load with 0000 → VERIFY.
- Locked, obs_load with obs=1110 → no err. Next sample 1100 matches and locked holds. Force 300 mismatches with LOSS_CNT=1000 → err_cnt saturates at 255.
- With LFSR_CHK_STICKY_EN: one mismatch → err_sticky=1 and stays 1 after relock. It clears only on reset.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side monitor for the 4-bit load/count-enable LFSR counter.
// It locks a local predictor onto the observed state stream and then flags every
// sample that leaves the expected sequence.
// Optional build macro LFSR_CHK_STICKY_EN adds the err_sticky output.
//
// state  | meaning
// HUNT   | no reference yet; the next usable sample seeds the predictor
// VERIFY | counting consecutive predicted samples toward lock
// LOCKED | synchronized; mismatches pulse err and the predictor flywheels
module lfsr_checker #(
  parameter int               width    = 4,
  parameter logic [width-1:0] TAPS     = 4'b1100,
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 2,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] data,
  input  logic [width-1:0] count_to,
  input  logic [width-1:0] obs,
  input  logic             obs_valid,
  input  logic             obs_load,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
`ifdef LFSR_CHK_STICKY_EN
  output logic             err_sticky,
`endif
  output logic [1:0]       state_o
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_V = LW'(LOSS_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [width-1:0]   pred_q, pred_d;
  logic [MW-1:0]      match_q, match_d;
  logic [LW-1:0]      miss_q, miss_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               sticky_q, sticky_d;

  // Generator successor: wrap to data at the terminal value, else shift in feedback.
  function automatic logic [width-1:0] nxt(input logic [width-1:0] x,
                                           input logic [width-1:0] d,
                                           input logic [width-1:0] ct);
    if (x == ct) return d;
    return {x[width-2:0], ^(x & TAPS)};
  endfunction

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT;
      pred_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  // Next-state, predictor and error bookkeeping for one sample.
  always_comb begin
    state_d   = state_q;
    pred_d    = pred_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;
    if (obs_valid) begin
      if (obs_load) begin
        // A fresh load reseeds unconditionally; there is nothing to compare against.
        pred_d = nxt(obs, data, count_to);
        case (state_q)
          HUNT: begin
            state_d = VERIFY;
            match_d = '0;
          end
          VERIFY:  match_d = '0;
          LOCKED:  miss_d  = '0;
          default: state_d = HUNT;
        endcase
      end else begin
        case (state_q)
          HUNT: begin
            // All-zero is the LFSR lockup word unless it is the terminal value.
            if (!((obs == '0) && (obs != count_to))) begin
              pred_d  = nxt(obs, data, count_to);
              match_d = '0;
              state_d = VERIFY;
            end
          end
          VERIFY: begin
            if (obs == pred_q) begin
              pred_d = nxt(pred_q, data, count_to);
              if (match_q + 1'b1 == LOCK_V) begin
                state_d = LOCKED;
                match_d = '0;
                miss_d  = '0;
              end else begin
                match_d = match_q + 1'b1;
              end
            end else begin
              pred_d  = nxt(obs, data, count_to);
              match_d = '0;
            end
          end
          LOCKED: begin
            // Flywheel on the prediction so a single bad sample cannot drag us off.
            pred_d = nxt(pred_q, data, count_to);
            if (obs == pred_q) begin
              miss_d = '0;
            end else begin
              err_d    = 1'b1;
              sticky_d = 1'b1;
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
              if (miss_q + 1'b1 == LOSS_V) begin
                state_d = HUNT;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + 1'b1;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
    locked_d = (state_d == LOCKED);
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign state_o = state_q;
`ifdef LFSR_CHK_STICKY_EN
  assign err_sticky = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: data=0111, count_to=1100, cycle 0111-1111-1110-1100.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data, count_to, obs;
  logic       obs_valid, obs_load;

  logic       locked, err;
  logic [7:0] err_cnt;
  logic [1:0] state_o;
  logic       s_locked, s_err;
  logic [7:0] s_err_cnt;
  logic [1:0] s_state_o;
`ifdef LFSR_CHK_STICKY_EN
  logic       err_sticky, s_err_sticky;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  lfsr_checker u_dut (
    .clk(clk), .reset(reset), .data(data), .count_to(count_to), .obs(obs),
    .obs_valid(obs_valid), .obs_load(obs_load), .locked(locked), .err(err),
    .err_cnt(err_cnt),
`ifdef LFSR_CHK_STICKY_EN
    .err_sticky(err_sticky),
`endif
    .state_o(state_o)
  );

  lfsr_checker #(.LOSS_CNT(1000)) u_sat (
    .clk(clk), .reset(reset), .data(data), .count_to(count_to), .obs(obs),
    .obs_valid(obs_valid), .obs_load(obs_load), .locked(s_locked), .err(s_err),
    .err_cnt(s_err_cnt),
`ifdef LFSR_CHK_STICKY_EN
    .err_sticky(s_err_sticky),
`endif
    .state_o(s_state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one sample for one clock; returns at the negedge after the capturing edge.
  task automatic sample(input logic [3:0] v, input logic ld);
    obs       = v;
    obs_load  = ld;
    obs_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    obs_valid = 1'b0;
    obs_load  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    obs_valid = 1'b0;
    obs_load  = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
  endtask

  task automatic relock();
    sample(4'b0111, 1'b0);
    sample(4'b1111, 1'b0);
    sample(4'b1110, 1'b0);
    sample(4'b1100, 1'b0);
  endtask

  initial begin
    data      = 4'b0111;
    count_to  = 4'b1100;
    obs       = 4'b0000;
    obs_valid = 1'b0;
    obs_load  = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    reset = 1'b0;

    // Acquire lock on the clean cycle.
    sample(4'b0111, 1'b0);
    check("acq1_state", 32'(state_o), 32'd1);
    sample(4'b1111, 1'b0);
    sample(4'b1110, 1'b0);
    check("acq3_locked", 32'(locked), 32'd0);
    sample(4'b1100, 1'b0);
    check("acq4_state", 32'(state_o), 32'd2);
    check("acq4_locked", 32'(locked), 32'd1);
    check("acq4_err_cnt", 32'(err_cnt), 32'd0);
    idle();
    check("idle_err", 32'(err), 32'd0);
    check("idle_state", 32'(state_o), 32'd2);

    // Single corrupted sample in place of 0111.
    sample(4'b1010, 1'b0);
    check("inj_err", 32'(err), 32'd1);
    check("inj_err_cnt", 32'(err_cnt), 32'd1);
    check("inj_locked", 32'(locked), 32'd1);
`ifdef LFSR_CHK_STICKY_EN
    check("inj_sticky", 32'(err_sticky), 32'd1);
`endif
    sample(4'b1111, 1'b0);
    check("fly_err", 32'(err), 32'd0);
    check("fly_locked", 32'(locked), 32'd1);
    sample(4'b1110, 1'b0);
    sample(4'b1100, 1'b0);
    check("fly_wrap_err", 32'(err), 32'd0);

    // Two consecutive misses drop lock.
    sample(4'b0000, 1'b0);
    check("loss1_err", 32'(err), 32'd1);
    check("loss1_state", 32'(state_o), 32'd2);
    sample(4'b0000, 1'b0);
    check("loss2_err_cnt", 32'(err_cnt), 32'd3);
    check("loss2_state", 32'(state_o), 32'd0);
    check("loss2_locked", 32'(locked), 32'd0);
    relock();
    check("resync_locked", 32'(locked), 32'd1);
`ifdef LFSR_CHK_STICKY_EN
    check("sticky_relock", 32'(err_sticky), 32'd1);
`endif

    // Mid-run reset clears everything.
    do_reset();
    @(negedge clk);
    check("mid_rst_cnt", 32'(err_cnt), 32'd0);
    check("mid_rst_state", 32'(state_o), 32'd0);
`ifdef LFSR_CHK_STICKY_EN
    check("sticky_rst", 32'(err_sticky), 32'd0);
`endif

    // Lockup word is ignored in HUNT unless it arrives as a load.
    sample(4'b0000, 1'b0);
    check("zero_hunt", 32'(state_o), 32'd0);
    sample(4'b0000, 1'b1);
    check("zero_load", 32'(state_o), 32'd1);

    // Load while locked reseeds without comparing.
    do_reset();
    relock();
    sample(4'b1110, 1'b1);
    check("ld_err", 32'(err), 32'd0);
    check("ld_state", 32'(state_o), 32'd2);
    sample(4'b1100, 1'b0);
    check("ld_next_err", 32'(err), 32'd0);
    check("ld_next_locked", 32'(locked), 32'd1);

    // Saturation on the instance that never loses lock.
    do_reset();
    relock();
    check("sat_locked0", 32'(s_locked), 32'd1);
    for (int i = 0; i < 300; i++) begin
      sample(4'b0000, 1'b0);
      if (i == 253) check("sat_254", 32'(s_err_cnt), 32'd254);
    end
    check("sat_255", 32'(s_err_cnt), 32'd255);
    check("sat_locked", 32'(s_locked), 32'd1);
    check("sat_err", 32'(s_err), 32'd1);
    check("dflt_cnt", 32'(err_cnt), 32'd2);
    check("dflt_hunt", 32'(state_o), 32'd0);
    idle();
    check("sat_hold", 32'(s_err_cnt), 32'd255);
    check("sat_idle_err", 32'(s_err), 32'd0);
    do_reset();
    @(negedge clk);
    check("sat_rst", 32'(s_err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
